// File: rtl/fpu_issue_rf.sv
// Issue stage for the pipelined FPU: one-entry issue register, RAW interlock on E1/E2,
// E3/WB operand bypass, FP register file written from WB, and saturating perf counters.
module fpu_issue_rf #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fc,
    input  logic [4:0]       in_fs,
    input  logic [4:0]       in_ft,
    input  logic [4:0]       in_fd,
    input  logic             in_wf,
    input  logic [4:0]       e1n,
    input  logic [4:0]       e2n,
    input  logic [4:0]       e3n,
    input  logic [4:0]       wn,
    input  logic             e1w,
    input  logic             e2w,
    input  logic             e3w,
    input  logic             ww,
    input  logic [31:0]      ed,
    input  logic [31:0]      wd,
    input  logic             fpu_stall,
    input  logic             e,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [2:0]       fc,
    output logic             wf,
    output logic [4:0]       fd,
    output logic             ein,
    output logic [CNT_W-1:0] n_issued,
    output logic [CNT_W-1:0] n_bubbles
);

    logic             hv_q, hv_d;
    logic [2:0]       fc_q;
    logic [4:0]       fs_q, ft_q, fd_q;
    logic             wf_q;
    logic             ein_q;
    logic [31:0]      rf_q [32];
    logic [CNT_W-1:0] iss_q, iss_d, bub_q, bub_d;

    logic use_ft, haz, show, fire, load, bub_inc;

    function automatic logic src_match(input logic [4:0] s, input logic [4:0] n, input logic w);
        return w & (s == n);
    endfunction

    // sqrt has no second source, so ft never interlocks for fc = 11x
    always_comb begin
        use_ft   = (fc_q[2:1] != 2'b11);
        haz      = hv_q & (src_match(fs_q, e1n, e1w) | src_match(fs_q, e2n, e2w) |
                           (use_ft & (src_match(ft_q, e1n, e1w) | src_match(ft_q, e2n, e2w))));
        show     = hv_q & ~haz;
        fire     = show & e;
        in_ready = ~hv_q | fire;
        load     = in_valid & in_ready;
        hv_d     = load | (hv_q & ~fire);
        bub_inc  = e & ~show;
        iss_d    = (fire && iss_q != '1) ? iss_q + 1'b1 : iss_q;
        bub_d    = (bub_inc && bub_q != '1) ? bub_q + 1'b1 : bub_q;
    end

    always_comb begin
        fc = '0;
        wf = 1'b0;
        fd = '0;
        if (show) begin
            fc = fc_q;
            wf = wf_q;
            fd = fd_q;
        end
    end

    // Youngest result wins: E3 ahead of WB ahead of the register file
    always_comb begin
        if (src_match(fs_q, e3n, e3w))      a = ed;
        else if (src_match(fs_q, wn, ww))   a = wd;
        else                                a = rf_q[fs_q];
        if (src_match(ft_q, e3n, e3w))      b = ed;
        else if (src_match(ft_q, wn, ww))   b = wd;
        else                                b = rf_q[ft_q];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hv_q  <= 1'b0;
            fc_q  <= '0;
            fs_q  <= '0;
            ft_q  <= '0;
            fd_q  <= '0;
            wf_q  <= 1'b0;
            ein_q <= 1'b0;
            iss_q <= '0;
            bub_q <= '0;
        end else begin
            hv_q  <= hv_d;
            ein_q <= 1'b1;
            iss_q <= iss_d;
            bub_q <= bub_d;
            if (load) begin
                fc_q <= in_fc;
                fs_q <= in_fs;
                ft_q <= in_ft;
                fd_q <= in_fd;
                wf_q <= in_wf;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)   rf_q <= '{default: '0};
        else if (ww) rf_q[wn] <= wd;
    end

    assign ein       = ein_q;
    assign n_issued  = iss_q;
    assign n_bubbles = bub_q;

endmodule

// File: tb/tb_fpu_issue_rf.sv
// Bench for fpu_issue_rf: behavioural FPU stage model plus an architectural reference
// (program-order register values, hazard distance in pipeline advances).
module tb_fpu_issue_rf;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          clrn, in_valid, in_ready, in_wf;
    logic [2:0]    in_fc, fc;
    logic [4:0]    in_fs, in_ft, in_fd, fd;
    logic [4:0]    e1n, e2n, e3n, wn;
    logic          e1w, e2w, e3w, ww, fpu_stall, e, wf, ein;
    logic [31:0]   ed, wd, a, b;
    logic [CW-1:0] n_issued, n_bubbles;

    always #5 clk = ~clk;

    fpu_issue_rf #(.CNT_W(CW)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .in_fc(in_fc), .in_fs(in_fs), .in_ft(in_ft), .in_fd(in_fd), .in_wf(in_wf),
        .e1n(e1n), .e2n(e2n), .e3n(e3n), .wn(wn),
        .e1w(e1w), .e2w(e2w), .e3w(e3w), .ww(ww),
        .ed(ed), .wd(wd), .fpu_stall(fpu_stall), .e(e),
        .a(a), .b(b), .fc(fc), .wf(wf), .fd(fd), .ein(ein),
        .n_issued(n_issued), .n_bubbles(n_bubbles)
    );

    // FPU pipeline model: index 0..3 = E1, E2, E3, WB
    logic [4:0]  sn [4];
    logic        sw [4];
    logic [31:0] sv [4];
    assign e1n = sn[0]; assign e1w = sw[0];
    assign e2n = sn[1]; assign e2w = sw[1];
    assign e3n = sn[2]; assign e3w = sw[2]; assign ed = sv[2];
    assign wn  = sn[3]; assign ww  = sw[3]; assign wd = sv[3];
    assign e   = ~fpu_stall & ein;

    typedef struct packed {
        logic [2:0] fc;
        logic [4:0] fs;
        logic [4:0] ft;
        logic [4:0] fd;
        logic       wf;
    } instr_t;

    // Reference state
    logic [31:0] arch [32];
    int          rfire [32];
    int          adv;
    logic        m_hv, m_wf;
    logic [2:0]  m_fc;
    logic [4:0]  m_fd;
    logic [31:0] m_a, m_b, m_res;
    int          m_pa, m_pb, m_iss, m_bub;

    instr_t      dq[$];
    bit          pend_dir;
    bit          div_watch;
    int          obs_bub;
    int unsigned nvec, nerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] res_of(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op[2:1] == 2'b11) return (x * 32'h9E3779B1) ^ 32'h5A5A0000;
        return (x * 32'h9E3779B1) + (y ^ {29'd0, op}) + 32'd1;
    endfunction

    function automatic int sat_inc(input int v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic next_instr();
        instr_t t;
        if (dq.size() > 0) begin
            t = dq.pop_front();
            pend_dir = 1'b1;
        end else begin
            t.fc = 3'($urandom_range(0, 7));
            t.fs = 5'($urandom_range(0, 7));
            t.ft = 5'($urandom_range(0, 7));
            t.fd = 5'($urandom_range(0, 7));
            t.wf = ($urandom_range(0, 3) != 0);
            pend_dir = 1'b0;
        end
        in_fc = t.fc; in_fs = t.fs; in_ft = t.ft; in_fd = t.fd; in_wf = t.wf;
    endtask

    task automatic clear_stages();
        for (int i = 0; i < 4; i++) begin
            sn[i] = '0; sw[i] = 1'b0; sv[i] = '0;
        end
    endtask

    // One clock: drive, check at mid-cycle, take the edge, advance the reference.
    task automatic cycle(input bit want_valid, input bit stall);
        bit haz, show, fire, rdy;
        fpu_stall = stall;
        in_valid  = want_valid;
        #2;
        haz  = m_hv && (adv < m_pa + 2 || adv < m_pb + 2);
        show = m_hv && !haz;
        fire = show && !stall;
        rdy  = !m_hv || fire;
        chk("in_ready", in_ready, rdy);
        chk("fc_wf_fd", {fc, wf, fd}, show ? {m_fc, m_wf, m_fd} : 9'd0);
        chk("ein", ein, 1'b1);
        if (show) begin
            chk("a", a, m_a);
            if (m_fc[2:1] != 2'b11) chk("b", b, m_b);
        end
        chk("n_issued", n_issued, m_iss);
        chk("n_bubbles", n_bubbles, m_bub);
        if (div_watch) begin
            chk("div_fc", fc, 3'b100);
            chk("div_ready", in_ready, 1'b0);
        end
        if (m_hv && wf === 1'b0) obs_bub++;
        @(posedge clk);
        #1;
        if (!stall) begin
            for (int i = 3; i > 0; i--) begin
                sn[i] = sn[i-1]; sw[i] = sw[i-1]; sv[i] = sv[i-1];
            end
            sn[0] = fire ? m_fd : 5'd0;
            sw[0] = fire && m_wf;
            sv[0] = fire ? m_res : 32'd0;
            adv++;
            if (fire) m_iss = sat_inc(m_iss);
            else      m_bub = sat_inc(m_bub);
            if (fire && m_wf) rfire[m_fd] = adv;
        end
        if (fire) m_hv = 1'b0;
        if (want_valid && rdy) begin
            m_hv  = 1'b1;
            m_fc  = in_fc; m_fd = in_fd; m_wf = in_wf;
            m_a   = arch[in_fs];
            m_b   = arch[in_ft];
            m_pa  = rfire[in_fs];
            m_pb  = (in_fc[2:1] == 2'b11) ? -100 : rfire[in_ft];
            m_res = res_of(in_fc, m_a, m_b);
            if (in_wf) arch[in_fd] = m_res;
            next_instr();
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0; in_valid = 1'b0; fpu_stall = 1'b0;
        clear_stages();
        #2;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_out", {fc, wf, fd}, 9'd0);
        chk("rst_ein", ein, 1'b0);
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_cnt", {n_issued, n_bubbles}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            arch[i] = '0; rfire[i] = -100;
        end
        adv = 0; m_hv = 1'b0; m_iss = 0; m_bub = 0;
        m_pa = -100; m_pb = -100;
        @(posedge clk); #1;
        clrn = 1'b1;
        @(posedge clk); #1;
        chk("ein_after_release", ein, 1'b1);
    endtask

    task automatic seed(input logic [4:0] n, input logic [31:0] v);
        sn[3] = n; sw[3] = 1'b1; sv[3] = v;
        arch[n] = v;
        cycle(1'b0, 1'b0);
    endtask

    task automatic run_dir(input string tag, input int exp_bub);
        int guard = 0;
        obs_bub = 0;
        while ((pend_dir || m_hv) && guard < 60) begin
            cycle(pend_dir, 1'b0);
            guard++;
        end
        if (guard >= 60) begin
            nvec++; nerr++;
            $error("FAIL %s_timeout: observed still busy expected drained", tag);
        end else begin
            chk({tag, "_bubbles"}, obs_bub, exp_bub);
        end
        repeat (4) cycle(1'b0, 1'b0);
    endtask

    initial begin
        int guard;
        nvec = 0; nerr = 0; obs_bub = 0; div_watch = 1'b0; pend_dir = 1'b0;
        clrn = 1'b1; in_valid = 1'b0; fpu_stall = 1'b0;
        clear_stages();
        next_instr();
        #1;
        do_reset();

        seed(5'd3, 32'h3F800000);
        seed(5'd1, 32'h40000000);
        seed(5'd2, 32'h40400000);

        dq.push_back('{3'b000, 5'd3, 5'd3, 5'd5, 1'b1});
        next_instr();
        run_dir("first_add", 0);

        dq.push_back('{3'b010, 5'd3, 5'd3, 5'd5, 1'b1});
        dq.push_back('{3'b000, 5'd5, 5'd3, 5'd6, 1'b1});
        next_instr();
        run_dir("dist1", 2);

        dq.push_back('{3'b010, 5'd3, 5'd3, 5'd5, 1'b1});
        dq.push_back('{3'b000, 5'd1, 5'd1, 5'd10, 1'b1});
        dq.push_back('{3'b000, 5'd5, 5'd3, 5'd6, 1'b1});
        next_instr();
        run_dir("dist2", 1);

        dq.push_back('{3'b010, 5'd3, 5'd3, 5'd5, 1'b1});
        dq.push_back('{3'b000, 5'd1, 5'd1, 5'd10, 1'b1});
        dq.push_back('{3'b000, 5'd1, 5'd1, 5'd11, 1'b1});
        dq.push_back('{3'b000, 5'd5, 5'd3, 5'd6, 1'b1});
        next_instr();
        run_dir("dist3", 0);

        dq.push_back('{3'b010, 5'd3, 5'd3, 5'd5, 1'b1});
        dq.push_back('{3'b000, 5'd1, 5'd1, 5'd10, 1'b1});
        dq.push_back('{3'b000, 5'd1, 5'd1, 5'd11, 1'b1});
        dq.push_back('{3'b000, 5'd1, 5'd1, 5'd12, 1'b1});
        dq.push_back('{3'b000, 5'd5, 5'd3, 5'd6, 1'b1});
        next_instr();
        run_dir("dist4", 0);

        dq.push_back('{3'b000, 5'd1, 5'd1, 5'd5, 1'b1});
        dq.push_back('{3'b110, 5'd9, 5'd5, 5'd8, 1'b1});
        next_instr();
        run_dir("sqrt_ft", 0);

        dq.push_back('{3'b100, 5'd1, 5'd2, 5'd7, 1'b1});
        next_instr();
        guard = 0;
        while (!m_hv && guard < 10) begin
            cycle(pend_dir, 1'b0);
            guard++;
        end
        div_watch = 1'b1;
        repeat (10) cycle(1'b0, 1'b1);
        div_watch = 1'b0;
        run_dir("div_stall", 0);

        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0);

        guard = 0;
        while (!m_hv && guard < 10) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        do_reset();
        dq.push_back('{3'b000, 5'd3, 5'd3, 5'd9, 1'b1});
        next_instr();
        run_dir("post_reset", 0);

        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
